raytracing_dispatcher: RTL

Drives the bank of raytracing workers one chunk of a scanline at a time and serialises their colour buffers into framebuffer writes. It sits directly downstream of the workers, and also upstream of them, since it owns their `activate` and coordinate inputs. A completed chunk is captured into a local drain buffer so the workers can start the next chunk while the previous one is written out. Frames are scanned row-major, top-left first.

---
 rtl/raytracing_dispatcher.sv | 120 ++++++++++++
 1 files changed

// File: rtl/raytracing_dispatcher.sv
// raytracing_dispatcher: launches worker chunks across a frame and drains captured colour buffers to the framebuffer.
// A local drain buffer lets the next chunk render while the previous one is written out.
module raytracing_dispatcher #(
   parameter int N_WORKERS = 4,
   parameter int JOBS_SUBDIVISION = 8,
   parameter int COLOR_W = 4,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int ADDR_W = 17
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic frame_done,
   output logic worker_activate,
   output logic [N_WORKERS*12-1:0] worker_pixel_start_x,
   output logic [11:0] worker_pixel_y,
   input  logic [N_WORKERS-1:0] worker_busy,
   input  logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_W-1:0] worker_buffer,
   output logic fb_wr_valid,
   input  logic fb_wr_ready,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [COLOR_W-1:0] fb_wr_data
);
   localparam int CHUNK = N_WORKERS*JOBS_SUBDIVISION;
   localparam int NCH = SCREEN_W/CHUNK;
   localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
   localparam int RW = SCREEN_H > 1 ? $clog2(SCREEN_H) : 1;
   localparam int IW = CHUNK > 1 ? $clog2(CHUNK) : 1;
   localparam int BW = CHUNK*COLOR_W;
   typedef enum logic [2:0] {L_IDLE, L_RUN, L_WAIT, L_HOLD, L_GAP} lstate_t;
   lstate_t lstate;
   logic [RW-1:0] row, drow, drow_n, nrow;
   logic [CW-1:0] chunk, dchunk, dchunk_n, nchunk;
   logic [IW-1:0] idx, idx_n;
   logic [BW-1:0] dbuf, dbuf_n;
   logic full_n, accept, last_acc, cap, frame_last, row_end;
   logic [N_WORKERS*12-1:0] sx_n;
   logic [11:0] y_n;
   logic [ADDR_W-1:0] addr_n;
   logic [COLOR_W-1:0] data_n;
   int pix_off;
   // fb_wr_valid doubles as the drain-buffer full flag
   always_comb begin
      accept = fb_wr_valid && fb_wr_ready;
      last_acc = accept && idx == IW'(CHUNK-1);
      frame_last = drow == RW'(SCREEN_H-1) && dchunk == CW'(NCH-1);
      cap = lstate == L_HOLD && (!fb_wr_valid || last_acc);
      full_n = cap || (fb_wr_valid && !last_acc);
      idx_n = (cap || last_acc) ? '0 : accept ? idx + IW'(1) : idx;
      dbuf_n = cap ? worker_buffer : dbuf;
      drow_n = cap ? row : drow;
      dchunk_n = cap ? chunk : dchunk;
      pix_off = ((int'(idx_n) % N_WORKERS)*JOBS_SUBDIVISION + int'(idx_n) / N_WORKERS)*COLOR_W;
      data_n = dbuf_n[pix_off +: COLOR_W];
      addr_n = ADDR_W'(int'(drow_n)*SCREEN_W + int'(dchunk_n)*CHUNK + int'(idx_n));
      row_end = chunk == CW'(NCH-1);
      nchunk = (lstate == L_IDLE || row_end) ? '0 : chunk + CW'(1);
      nrow = lstate == L_IDLE ? '0 : row_end ? row + RW'(1) : row;
      y_n = 12'(int'(nrow) - SCREEN_H/2);
      for (int w = 0; w < N_WORKERS; w++)
         sx_n[w*12 +: 12] = 12'(int'(nchunk)*CHUNK - SCREEN_W/2 + w);
   end
   assign frame_done = last_acc && frame_last;
   always_ff @(posedge clk) begin
      if (rst) begin
         lstate <= L_IDLE;
         row <= '0;
         chunk <= '0;
         busy <= 1'b0;
         worker_activate <= 1'b0;
         worker_pixel_start_x <= '0;
         worker_pixel_y <= '0;
         fb_wr_valid <= 1'b0;
         idx <= '0;
         dbuf <= '0;
         drow <= '0;
         dchunk <= '0;
         fb_wr_addr <= '0;
         fb_wr_data <= '0;
      end else begin
         fb_wr_valid <= full_n;
         idx <= idx_n;
         dbuf <= dbuf_n;
         drow <= drow_n;
         dchunk <= dchunk_n;
         fb_wr_addr <= addr_n;
         fb_wr_data <= data_n;
         if (frame_done) busy <= 1'b0;
         case (lstate)
            L_IDLE: if (start && !busy) begin
               busy <= 1'b1;
               row <= nrow;
               chunk <= nchunk;
               worker_pixel_start_x <= sx_n;
               worker_pixel_y <= y_n;
               worker_activate <= 1'b1;
               lstate <= L_RUN;
            end
            L_RUN: if (|worker_busy) lstate <= L_WAIT;
            L_WAIT: if (~|worker_busy) lstate <= L_HOLD;
            L_HOLD: if (cap) begin
               worker_activate <= 1'b0;
               lstate <= L_GAP;
            end
            L_GAP: if (row == RW'(SCREEN_H-1) && row_end) lstate <= L_IDLE;
            else begin
               row <= nrow;
               chunk <= nchunk;
               worker_pixel_start_x <= sx_n;
               worker_pixel_y <= y_n;
               worker_activate <= 1'b1;
               lstate <= L_RUN;
            end
            default: lstate <= L_IDLE;
         endcase
      end
   end
endmodule
